rv_branch_predictor: RTL and testbench

//  Bimodal branch predictor plus direct-mapped BTB. It is read by IF with the fetch PC and updated by EX

---
 rtl/rv_branch_predictor_if.sv | 30 +++
 rtl/rv_branch_predictor.sv | 93 +++++++++
 tb/tb_rv_branch_predictor.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/rv_branch_predictor_if.sv
// Fetch-side lookup, EX-side resolution and redirect signals of the branch predictor.
interface rv_branch_predictor_if #(
  parameter int unsigned MXLEN = 32
);
  logic [MXLEN-1:0] if_pc_i;
  logic             if_pred_taken_o;
  logic [MXLEN-1:0] if_pred_target_o;
  logic             ex_valid_i;
  logic [MXLEN-1:0] ex_pc_i;
  logic             ex_taken_i;
  logic [MXLEN-1:0] ex_target_i;
  logic             ex_pred_taken_i;
  logic [MXLEN-1:0] ex_pred_target_i;
  logic             redirect_o;
  logic [MXLEN-1:0] redirect_pc_o;

  // Pipeline side: drives fetch PC and resolved branches, consumes predictions/redirects
  modport master (
    output if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    input  if_pred_taken_o, if_pred_target_o, redirect_o, redirect_pc_o
  );

  // Predictor side
  modport slave (
    input  if_pc_i, ex_valid_i, ex_pc_i, ex_taken_i, ex_target_i,
           ex_pred_taken_i, ex_pred_target_i,
    output if_pred_taken_o, if_pred_target_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/rv_branch_predictor.sv
// Bimodal (2-bit counter) predictor with a direct-mapped BTB. Looked up
// combinationally by IF, trained by EX, and raises a registered one-cycle
// redirect when EX finds the carried prediction was wrong.
module rv_branch_predictor #(
  parameter int unsigned MXLEN = 32,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rv_branch_predictor_if.slave bp
);
  localparam int unsigned ENTRIES = 2 ** IDX_W;

  logic [1:0]       cnt_q     [ENTRIES];
  logic             btb_vld_q [ENTRIES];
  logic [TAG_W-1:0] btb_tag_q [ENTRIES];
  logic [MXLEN-1:0] btb_tgt_q [ENTRIES];

  logic             redirect_q;
  logic [MXLEN-1:0] redirect_pc_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             mis;
  logic [MXLEN-1:0] fix_pc;

  // Fetch lookup from registered tables only; same-cycle updates are not bypassed
  always_comb begin
    lk_idx   = bp.if_pc_i[IDX_W+1:2];
    lk_tag   = bp.if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    lk_hit   = btb_vld_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    lk_taken = lk_hit && cnt_q[lk_idx][1];
    bp.if_pred_taken_o  = lk_taken;
    bp.if_pred_target_o = lk_taken ? btb_tgt_q[lk_idx] : bp.if_pc_i + MXLEN'(4);
  end

  // Resolve the EX branch: table index/tag, mispredict detection, correct next PC
  always_comb begin
    up_idx = bp.ex_pc_i[IDX_W+1:2];
    up_tag = bp.ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    mis    = bp.ex_valid_i &&
             ((bp.ex_pred_taken_i != bp.ex_taken_i) ||
              (bp.ex_taken_i && (bp.ex_pred_target_i != bp.ex_target_i)));
    fix_pc = bp.ex_taken_i ? bp.ex_target_i : bp.ex_pc_i + MXLEN'(4);
  end

  // Counters, BTB valid bits and redirect register; reset wins over any update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < ENTRIES; k++) begin
        cnt_q[k]     <= 2'b01;
        btb_vld_q[k] <= 1'b0;
      end
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= mis;
      if (mis) begin
        redirect_pc_q <= fix_pc;
      end
      if (bp.ex_valid_i) begin
        if (bp.ex_taken_i) begin
          if (cnt_q[up_idx] != 2'b11) begin
            cnt_q[up_idx] <= cnt_q[up_idx] + 2'b01;
          end
          btb_vld_q[up_idx] <= 1'b1;
        end else if (cnt_q[up_idx] != 2'b00) begin
          cnt_q[up_idx] <= cnt_q[up_idx] - 2'b01;
        end
      end
    end
  end

  // BTB tag/target payload: only meaningful behind a valid bit, so no reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && bp.ex_valid_i && bp.ex_taken_i) begin
      btb_tag_q[up_idx] <= up_tag;
      btb_tgt_q[up_idx] <= bp.ex_target_i;
    end
  end

  // Registered redirect outputs
  always_comb begin
    bp.redirect_o    = redirect_q;
    bp.redirect_pc_o = redirect_pc_q;
  end
endmodule

// File: tb/tb_rv_branch_predictor.sv
// Directed, table-driven bench for rv_branch_predictor.
module tb_rv_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rv_branch_predictor_if #(.MXLEN(32)) bus ();

  rv_branch_predictor #(.MXLEN(32), .IDX_W(6), .TAG_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bp    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        ptaken;
    logic [31:0] ptgt;
    logic [31:0] ifpc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_red;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic t, logic [31:0] tg,
                              logic pt, logic [31:0] ptg, logic [31:0] ifpc,
                              logic ept, logic [31:0] eptg, logic ered, logic [31:0] erpc);
    vec_t r;
    r.valid = v; r.pc = pc; r.taken = t; r.tgt = tg; r.ptaken = pt; r.ptgt = ptg;
    r.ifpc = ifpc; r.e_pt = ept; r.e_ptgt = eptg; r.e_red = ered; r.e_rpc = erpc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ex_valid_i       = v.valid;
    bus.ex_pc_i          = v.pc;
    bus.ex_taken_i       = v.taken;
    bus.ex_target_i      = v.tgt;
    bus.ex_pred_taken_i  = v.ptaken;
    bus.ex_pred_target_i = v.ptgt;
    bus.if_pc_i          = v.ifpc;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 0);
    drive(idle);

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect", {31'b0, bus.redirect_o}, 32'h0);
    chk("rst_redirect_pc", bus.redirect_pc_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //      valid pc        tk tgt       ptk ptgt      ifpc          e_pt e_ptgt     e_red e_rpc
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h100,      0, 32'h104,      0, 32'h0));   // lookup after reset
    vt.push_back(mk(1, 32'h100, 1, 32'h80, 0, 32'h0,  32'h100,      0, 32'h104,      1, 32'h80));  // first taken, no bypass
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h100,      1, 32'h80,       0, 32'h80));  // cnt 10, pulse ends
    vt.push_back(mk(1, 32'h100, 1, 32'h80, 1, 32'h80, 32'h100,      1, 32'h80,       0, 32'h80));  // ->11
    vt.push_back(mk(1, 32'h100, 1, 32'h80, 1, 32'h80, 32'h100,      1, 32'h80,       0, 32'h80));  // 11 stays
    vt.push_back(mk(1, 32'h100, 1, 32'h80, 1, 32'h80, 32'h100,      1, 32'h80,       0, 32'h80));  // 11 stays
    vt.push_back(mk(1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100,      1, 32'h80,       1, 32'h104)); // ->10
    vt.push_back(mk(1, 32'h100, 0, 32'h80, 1, 32'h80, 32'h100,      1, 32'h80,       1, 32'h104)); // ->01
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h100,      0, 32'h104,      0, 32'h104)); // weak NT
    vt.push_back(mk(1, 32'h200, 0, 32'h0,  1, 32'h300,32'h200,      0, 32'h204,      1, 32'h204)); // NT mispredict, ->00
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h200,      0, 32'h204,      0, 32'h204));
    vt.push_back(mk(1, 32'h100, 1, 32'h80, 0, 32'h0,  32'h100,      0, 32'h104,      1, 32'h80));  // 00->01
    vt.push_back(mk(1, 32'h100, 1, 32'h80, 0, 32'h0,  32'h100,      0, 32'h104,      1, 32'h80));  // 01->10
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h200,      0, 32'h204,      0, 32'h80));  // alias, tag miss
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h100,      1, 32'h80,       0, 32'h80));
    vt.push_back(mk(1, 32'h100, 1, 32'h90, 1, 32'h80, 32'h100,      1, 32'h80,       1, 32'h90));  // target mispredict
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'h100,      1, 32'h90,       0, 32'h90));  // new target
    vt.push_back(mk(0, 32'h0,   0, 32'h0,  0, 32'h0,  32'hFFFFFFFC, 0, 32'h0,        0, 32'h90));  // pc+4 wraps

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d_pred_taken", i), {31'b0, bus.if_pred_taken_o}, {31'b0, vt[i].e_pt});
      chk($sformatf("v%0d_pred_target", i), bus.if_pred_target_o, vt[i].e_ptgt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_redirect", i), {31'b0, bus.redirect_o}, {31'b0, vt[i].e_red});
      chk($sformatf("v%0d_redirect_pc", i), bus.redirect_pc_o, vt[i].e_rpc);
    end

    // Reset coinciding with a mispredicting update at 0x140 (index 16)
    @(negedge clk);
    drive(mk(1, 32'h140, 1, 32'h40, 0, 32'h0, 32'h100, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstupd_redirect", {31'b0, bus.redirect_o}, 32'h0);
    chk("rstupd_redirect_pc", bus.redirect_pc_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(idle);
    #1;
    chk("rstupd_pred_100", {31'b0, bus.if_pred_taken_o}, 32'h0);
    chk("rstupd_tgt_100", bus.if_pred_target_o, 32'h104);
    bus.if_pc_i = 32'h140;
    #1;
    chk("rstupd_pred_140", {31'b0, bus.if_pred_taken_o}, 32'h0);
    chk("rstupd_tgt_140", bus.if_pred_target_o, 32'h144);
    @(posedge clk);
    #1;
    chk("rstupd_idle_redirect", {31'b0, bus.redirect_o}, 32'h0);

    // After reset, training 0x140 twice makes it predicted taken
    @(negedge clk);
    drive(mk(1, 32'h140, 1, 32'h40, 0, 32'h0, 32'h140, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    drive(idle);
    bus.if_pc_i = 32'h140;
    #1;
    chk("retrain_pred_140", {31'b0, bus.if_pred_taken_o}, 32'h1);
    chk("retrain_tgt_140", bus.if_pred_target_o, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
